mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencer for the multi-cycle M-extension multiply/divide unit in the EX stage.
- Accepts a mul/div request from decode/EX, starts the unit, and holds the pipeline while the unit works.
- Drives mul_stall, which freezes the IF/ID/EX/MEM registers and the ALU path of the writeback register.
- Releases the stall for exactly one write-back-enable cycle. Handles kill (trap/flush), a downstream external stall, and the divide-by-zero early-out.

Parameters:
- MUL_LAT, 3: total stall cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0); must be ≥2.
- DIV_LAT, 33: total stall cycles for DIV/DIVU/REM/REMU (funct3[2]=1); must be ≥2.
- CNT_W, 6: latency counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mul_req  in  1  EX holds a valid M-extension instruction.
- mul_funct3  in  3  funct3 of that instruction.
- div_by_zero  in  1  divisor operand == 0; sampled only at accept.
- kill  in  1  trap/flush; aborts any operation in flight.
- ext_stall  in  1  downstream (memory) stall; the result must be held while asserted.
- mul_start  out  1  one-cycle start pulse to the multiply/divide unit.
- mul_op  out  3  latched funct3, stable from accept until return to IDLE.
- mul_stall  out  1  pipeline freeze request.
- mul_busy  out  1  state != IDLE.
- mul_wb_en  out  1  result valid; EX→MEM register captures the unit output.
- mul_stall_cnt  out  32  saturating count of cycles with mul_stall=1.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, mul_op=0, mul_stall_cnt=0. All outputs 0 while in reset.
- States: IDLE, BUSY, DONE.
- Accept (IDLE, mul_req=1, kill=0), in the same cycle (combinational):
  - mul_start=1, mul_stall=1.
  - Register mul_op←mul_funct3.
  - If div_by_zero and funct3[2]=1: next state is DONE.
  - Otherwise: next state is BUSY, with cnt←LAT-1 (MUL_LAT or DIV_LAT selected by funct3[2]).
- IDLE otherwise: all combinational outputs 0. mul_req with kill=1 is not accepted.
- BUSY:
  - mul_stall=1, mul_busy=1.
  - If cnt==1: go to DONE. Else cnt←cnt-1.
- DONE:
  - mul_stall=0, mul_wb_en=1.
  - If ext_stall=1: stay in DONE, keep mul_wb_en=1 and mul_op held.
  - Else: go to IDLE.
  - mul_req is ignored in DONE (it is the same instruction advancing).
  - A back-to-back mul is accepted in the following IDLE cycle.
- Latency: a request accepted at cycle T gives mul_stall=1 for T..T+LAT-1 and mul_wb_en=1 at T+LAT (when ext_stall=0). Divide-by-zero gives stall at T only and wb_en at T+1.
- kill, any state: next state IDLE, cnt←0.
  - Combinational outputs are gated in the kill cycle: mul_stall=0, mul_wb_en=0.
  - No mul_start is issued in a kill cycle.
  - kill has priority over every other transition.
- ext_stall in BUSY has no effect; counting continues.
- mul_stall_cnt increments on every cycle with mul_stall=1 and saturates at 32'hFFFFFFFF. It is not cleared by kill.
- Async reset mid-operation returns everything to the reset values immediately. There is no partial result or pulse.

Decomposition:
- Shared package: state enum (IDLE/BUSY/DONE), funct3 constants for the 8 M ops, and the MUL_LAT/DIV_LAT defaults.
- One natural sub-module: mul_lat_counter (loadable down-counter with a "last" flag, CNT_W wide).
- FSM, output decode and the perf counter stay in mul_seq_ctrl.

Test Plan:
- MUL (funct3=000) at T, ext_stall=0 → mul_start@T only; mul_stall=1 @T,T+1,T+2; mul_wb_en=1 @T+3; IDLE @T+4; mul_stall_cnt=3.
- DIVU (funct3=101), div_by_zero=0 → 33 stall cycles, then wb_en one cycle; mul_op=101 throughout; mul_stall_cnt=33.
- DIV with div_by_zero=1 at T → mul_stall=1 @T only; mul_wb_en=1 @T+1; BUSY never entered.
- MUL accepted at T, kill=1 @T+1 → mul_stall=0 @T+1; IDLE @T+2; no mul_wb_en; a new MUL at T+2 gets full 3-cycle latency.
- MUL reaches DONE @T+3 with ext_stall=1 for 2 cycles → mul_wb_en=1 @T+3..T+5, mul_stall=0; IDLE @T+6; mul_req held high in DONE not re-accepted.
- rst=0 asserted asynchronously mid-BUSY of a DIV → all outputs 0 immediately; after release, MUL completes normally with mul_stall_cnt counting from 0.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// rtl/mul_seq_ctrl_pkg.sv - shared types and constants for the M-extension sequencer
package mul_seq_ctrl_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   // funct3 encodings of the eight M-extension operations
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // Default latencies (total stall cycles) and counter width
   localparam int MUL_LAT_DEF = 3;
   localparam int DIV_LAT_DEF = 33;
   localparam int CNT_W_DEF   = 6;

   // Divide/remainder ops all have funct3[2] set
   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/mul_lat_counter.sv
// rtl/mul_lat_counter.sv - loadable down-counter with a last-cycle flag
module mul_lat_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   // Clear wins over load, load wins over decrement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Final BUSY cycle is the one where the count has reached one
   assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - stall/write-back sequencer for the multi-cycle mul/div unit
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mul_req,
   input  logic [2:0]  mul_funct3,
   input  logic        div_by_zero,
   input  logic        kill,
   input  logic        ext_stall,
   output logic        mul_start,
   output logic [2:0]  mul_op,
   output logic        mul_stall,
   output logic        mul_busy,
   output logic        mul_wb_en,
   output logic [31:0] mul_stall_cnt
);

   // The accept cycle is itself a stall cycle, so the counter holds LAT-1
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   mul_state_e       state;
   mul_state_e       state_nxt;
   logic             accept;
   logic             start_c;
   logic             stall_c;
   logic             wb_en_c;
   logic             cnt_clr;
   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;

   assign cnt_load_val = is_div_op(mul_funct3) ? DIV_LOAD : MUL_LOAD;

   mul_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode; kill overrides everything and silences outputs
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      start_c   = 1'b0;
      stall_c   = 1'b0;
      wb_en_c   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      if (kill) begin
         state_nxt = ST_IDLE;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mul_req) begin
                  accept  = 1'b1;
                  start_c = 1'b1;
                  stall_c = 1'b1;
                  if (div_by_zero && is_div_op(mul_funct3)) begin
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_BUSY;
                     cnt_load  = 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               stall_c = 1'b1;
               if (cnt_last) begin
                  state_nxt = ST_DONE;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            ST_DONE: begin
               // mul_req here is the same instruction moving on, never a new one
               wb_en_c = 1'b1;
               if (!ext_stall) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Combinational outputs are forced low while reset is held
   assign mul_start = start_c & rst;
   assign mul_stall = stall_c & rst;
   assign mul_wb_en = wb_en_c & rst;
   assign mul_busy  = (state != ST_IDLE);

   // Operation code captured at accept and held for the unit and write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_op <= 3'b000;
      end else if (accept) begin
         mul_op <= mul_funct3;
      end
   end

   // Saturating count of stalled cycles; survives kill, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_stall_cnt <= 32'd0;
      end else if (mul_stall && (mul_stall_cnt != 32'hFFFF_FFFF)) begin
         mul_stall_cnt <= mul_stall_cnt + 32'd1;
      end
   end

endmodule
